// File: rtl/fifo_serial_tx.sv
// FIFO read-side drain: pops one word per frame and sends it as an async serial frame
// (start, data LSB first, optional even parity, stop) on tx.
module fifo_serial_tx #(
  parameter int DATA_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CLK_PRE  = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, WAIT, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [CW-1:0]         clk_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  parity;
  logic                  bit_end;

  assign fifo_rd_en = !reset && (state == IDLE) && enable && !fifo_empty;
  assign bit_end    = (clk_cnt == CLK_LAST);
  assign shift_nxt  = shift >> 1;

  // tx and frame_done are registered one state ahead so each bit starts on a state boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (fifo_rd_en) begin
            state <= WAIT;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          shift   <= fifo_rd_data;
          parity  <= ^fifo_rd_data;
          clk_cnt <= '0;
          tx      <= 1'b0;
          state   <= START;
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            shift   <= shift_nxt;
            if (bit_cnt == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                tx    <= parity;
                state <= PARITY;
              end else begin
                tx         <= 1'b1;
                state      <= STOP;
                frame_done <= (CLKS_PER_BIT == 1);
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              tx      <= shift_nxt[0];
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            clk_cnt    <= '0;
            tx         <= 1'b1;
            state      <= STOP;
            frame_done <= (CLKS_PER_BIT == 1);
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            clk_cnt    <= clk_cnt + CW'(1);
            frame_done <= (clk_cnt == CLK_PRE);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: FIFO model feeds the DUT, a monitor rebuilds each frame from tx
// and compares it against a frame built from the popped word.
module tb_fifo_serial_tx;
  localparam int CPB   = 4;
  localparam int NBITS = 7;
  localparam int FLEN  = NBITS * CPB;

  logic       clk = 1'b0, reset = 1'b1, enable = 1'b0, fifo_empty = 1'b1;
  logic [3:0] fifo_rd_data = '0;
  logic       fifo_rd_en, tx, busy, frame_done;

  logic       enable1 = 1'b0, empty1 = 1'b1;
  logic [3:0] data1 = '0;
  logic       rd_en1, tx1, busy1, done1;

  fifo_serial_tx dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
    .frame_done(frame_done));

  fifo_serial_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut1 (
    .clk(clk), .reset(reset), .enable(enable1), .fifo_empty(empty1),
    .fifo_rd_data(data1), .fifo_rd_en(rd_en1), .tx(tx1), .busy(busy1),
    .frame_done(done1));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [3:0] fq[$];
  logic [3:0] exp_q[$];
  int pops = 0, done_frames = 0;
  bit pop_req = 1'b0;
  bit in_frame = 1'b0, after_frame = 1'b0, ctl_ok;
  int cyc = 0, gap = 0, last_gap = -1;
  logic [3:0] last_word = '0;
  bit [NBITS-1:0] exp_bits;
  string act_s, exp_s;

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void check_s(string name, string act, string exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [3:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit, input string name);
    int n = 0;
    while (done_frames < target && n < limit) begin
      step();
      n++;
    end
    check(name, done_frames, target);
  endtask

  task automatic wait_cyc(input int c, input int limit, input string name);
    int n = 0;
    while (!(in_frame && cyc == c) && n < limit) begin
      step();
      n++;
    end
    check(name, (in_frame && cyc == c) ? 1 : 0, 1);
  endtask

  // FIFO model: the pop decision is taken just before the edge that samples rd_en,
  // and rd_data/empty change just after it.
  initial forever begin
    @(negedge clk);
    #3;
    pop_req = fifo_rd_en && !fifo_empty && !reset;
    if (fifo_rd_en) check("rd_en_guard", (fifo_empty || busy) ? 1 : 0, 0);
    @(posedge clk);
    #1;
    if (pop_req) begin
      fifo_rd_data = fq.pop_front();
      exp_q.push_back(fifo_rd_data);
      pops++;
      fifo_empty = (fq.size() == 0);
    end
  end

  // Monitor: a frame begins at the first low tx; expected cycles come from the popped word.
  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
      after_frame = 1'b0;
      exp_q.delete();
      gap = 0;
    end else begin
      if (!in_frame) begin
        if (after_frame) begin
          check("busy_after_frame", busy, 0);
          after_frame = 1'b0;
        end
        check("idle_frame_done", frame_done, 0);
        if (tx == 1'b0) begin
          int ones;
          check("frame_expected", exp_q.size(), 1);
          last_word = (exp_q.size() > 0) ? exp_q.pop_front() : 4'h0;
          ones = 0;
          exp_bits = '0;
          exp_bits[NBITS-1] = 1'b1;
          for (int i = 0; i < 4; i++) begin
            exp_bits[1+i] = last_word[i];
            ones += int'(last_word[i]);
          end
          exp_bits[5] = (ones % 2) == 1;
          act_s = "";
          exp_s = "";
          ctl_ok = 1'b1;
          cyc = 0;
          last_gap = gap;
          in_frame = 1'b1;
        end else begin
          gap++;
        end
      end
      if (in_frame) begin
        act_s = {act_s, tx ? "1" : "0"};
        exp_s = {exp_s, exp_bits[cyc / CPB] ? "1" : "0"};
        if (frame_done != (cyc == FLEN - 1) || !busy) ctl_ok = 1'b0;
        cyc++;
        if (cyc == FLEN) begin
          check_s("frame_tx", act_s, exp_s);
          check("frame_done_busy", ctl_ok, 1);
          in_frame = 1'b0;
          after_frame = 1'b1;
          gap = 0;
          done_frames++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0, nrand;
    logic [3:0] wb, wc;
    string s_tx, s_done;

    // Reset held with both DUTs asked to fetch: nothing may move.
    enable = 1'b1;
    enable1 = 1'b1;
    empty1 = 1'b0;
    repeat (3) step();
    check("reset_outputs", {tx, busy, fifo_rd_en, frame_done}, 4'b1000);
    check("reset_outputs1", {tx1, busy1, rd_en1, done1}, 4'b1000);
    empty1 = 1'b1;
    enable1 = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_empty", {tx, busy, fifo_rd_en}, 3'b100);
    end

    // Single word, defaults
    p0 = pops;
    d0 = done_frames;
    push_word(4'b0100);
    wait_done(d0 + 1, 200, "single_frame_timeout");
    check("single_pop", pops - p0, 1);
    repeat (3) step();

    // Back-to-back frames
    p0 = pops;
    d0 = done_frames;
    push_word(4'b1111);
    push_word(4'b0100);
    wait_done(d0 + 2, 300, "b2b_timeout");
    check("b2b_gap", last_gap, 2);
    check("b2b_pops", pops - p0, 2);
    check("b2b_empty", fifo_empty, 1);
    repeat (3) step();

    // enable dropped during DATA
    d0 = done_frames;
    push_word(4'b0011);
    push_word(4'b1001);
    push_word(4'b0110);
    wait_cyc(10, 200, "enable_drop_reach");
    enable = 1'b0;
    p0 = pops;
    wait_done(d0 + 1, 100, "enable_drop_finish");
    repeat (40) step();
    check("no_fetch_disabled", pops - p0, 0);
    check("idle_disabled", busy, 0);
    enable = 1'b1;
    wait_done(d0 + 3, 300, "enable_restart");
    check("restart_pops", pops - p0, 2);
    repeat (3) step();

    // Reset during PARITY aborts the frame; next frame carries the following word
    wb = 4'($urandom);
    wc = 4'($urandom);
    push_word(4'b1101);
    push_word(wb);
    push_word(wc);
    wait_cyc(21, 200, "parity_reach");
    reset = 1'b1;
    #1;
    check("reset_async", {tx, busy, frame_done}, 3'b100);
    repeat (2) step();
    reset = 1'b0;
    d0 = done_frames;
    wait_done(d0 + 1, 200, "after_reset_frame");
    check("after_reset_word", last_word, wb);
    wait_done(d0 + 2, 200, "after_reset_frame2");
    check("after_reset_word2", last_word, wc);
    repeat (3) step();

    // Randomized traffic with enable toggling
    d0 = done_frames;
    nrand = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if ($urandom_range(0, 9) == 0) begin
        push_word(4'($urandom));
        nrand++;
      end
      if ($urandom_range(0, 15) == 0) enable = ($urandom_range(0, 2) != 0);
    end
    enable = 1'b1;
    for (int n = 0; n < 3000 && !(fq.size() == 0 && !busy && !in_frame && exp_q.size() == 0); n++)
      step();
    check("random_frames", done_frames - d0, nrand);

    // CLKS_PER_BIT=1, no parity, word 1010
    data1 = 4'b1010;
    empty1 = 1'b0;
    enable1 = 1'b1;
    #1;
    check("nopar_rd_en", rd_en1, 1);
    @(posedge clk);
    #1;
    empty1 = 1'b1;
    s_tx = "";
    s_done = "";
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      s_tx = {s_tx, tx1 ? "1" : "0"};
      s_done = {s_done, done1 ? "1" : "0"};
      check("nopar_single_pop", rd_en1, 0);
    end
    check_s("nopar_tx", s_tx, "1001011");
    check_s("nopar_done", s_done, "0000001");
    @(negedge clk);
    check("nopar_busy_after", busy1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
